alu_issue_stage: RTL

//  ID->EX issue stage that feeds the ALU: decodes MIPS opcode/funct into the
//  4-bit ALU ctrl code, selects and extends the operands, and presents
//  in_1/in_2/ctrl to the EX stage. Valid/ready on both sides, with a
//  2-entry skid buffer so that id_ready is a registered signal.

---
 rtl/alu_issue_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes MIPS opcode/funct into an ALU control code, selects
// operands, and buffers up to two ops behind a registered id_ready.
module alu_issue_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [5:0]        id_opcode,
   input  logic [5:0]        id_funct,
   input  logic [DATA_W-1:0] id_rs_val,
   input  logic [DATA_W-1:0] id_rt_val,
   input  logic [15:0]       id_imm,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] ex_in_1,
   output logic [DATA_W-1:0] ex_in_2,
   output logic [3:0]        ex_ctrl,
   output logic              ex_is_branch,
   output logic              ex_branch_ne,
   output logic              ex_illegal,
   output logic [CNT_W-1:0]  issue_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] in_1;
      logic [DATA_W-1:0] in_2;
      logic [3:0]        ctrl;
      logic              is_branch;
      logic              branch_ne;
      logic              illegal;
   } op_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t state, state_nx;
   op_t    dec, main_q, skid_q;
   logic   accept, consume;
   logic   ld_main_dec, ld_main_skid, ld_skid;

   function automatic op_t decode(input logic [5:0] opcode, input logic [5:0] funct,
                                  input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt,
                                  input logic [15:0] imm);
      op_t d;
      d         = '0;
      d.in_1    = rs;
      d.in_2    = rt;
      d.ctrl    = 4'b0010;
      case (opcode)
         6'b000000: begin
            case (funct)
               6'b100000: d.ctrl = 4'b0010;
               6'b100010: d.ctrl = 4'b0110;
               6'b100110: d.ctrl = 4'b0000;
               6'b100101: d.ctrl = 4'b0001;
               default:   d.illegal = 1'b1;
            endcase
         end
         6'b001000, 6'b100011, 6'b101011: d.in_2 = DATA_W'(signed'(imm));
         6'b001110: begin d.ctrl = 4'b0000; d.in_2 = DATA_W'(imm); end
         6'b001101: begin d.ctrl = 4'b0001; d.in_2 = DATA_W'(imm); end
         6'b000100, 6'b000101: begin
            d.ctrl      = 4'b0110;
            d.is_branch = 1'b1;
            d.branch_ne = opcode[0];
         end
         default: d.illegal = 1'b1;
      endcase
      // Illegal ops still flow to EX, but with neutral operands.
      if (d.illegal) begin
         d.in_1      = '0;
         d.in_2      = '0;
         d.ctrl      = 4'b0010;
         d.is_branch = 1'b0;
         d.branch_ne = 1'b0;
      end
      return d;
   endfunction

   assign dec      = decode(id_opcode, id_funct, id_rs_val, id_rt_val, id_imm);
   assign id_ready = (state != TWO) & ~rst;
   assign ex_valid = (state != EMPTY);
   assign accept   = id_valid & id_ready;
   assign consume  = ex_valid & ex_ready;

   always_comb begin
      state_nx     = state;
      ld_main_dec  = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state)
         EMPTY: if (accept) begin state_nx = ONE; ld_main_dec = 1'b1; end
         ONE: begin
            if (accept & consume)  ld_main_dec = 1'b1;
            else if (accept)       begin state_nx = TWO; ld_skid = 1'b1; end
            else if (consume)      state_nx = EMPTY;
         end
         TWO: if (consume) begin state_nx = ONE; ld_main_skid = 1'b1; end
         default: state_nx = EMPTY;
      endcase
      if (flush) begin
         state_nx     = EMPTY;
         ld_main_dec  = 1'b0;
         ld_main_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         issue_cnt <= '0;
      end else begin
         state <= state_nx;
         if (ld_main_dec)       main_q <= dec;
         else if (ld_main_skid) main_q <= skid_q;
         if (ld_skid)           skid_q <= dec;
         // A handshake in a flush cycle still leaves the stage, so it counts.
         if (consume)           issue_cnt <= issue_cnt + 1'b1;
      end
   end

   assign ex_in_1      = main_q.in_1;
   assign ex_in_2      = main_q.in_2;
   assign ex_ctrl      = main_q.ctrl;
   assign ex_is_branch = main_q.is_branch;
   assign ex_branch_ne = main_q.branch_ne;
   assign ex_illegal   = main_q.illegal;

endmodule
